// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: WIDTH-bit add/subtract, one 4-bit lookahead group per pipeline stage.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef CLA_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int NG = WIDTH / 4;
   if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a positive multiple of 4");
   end
   logic [WIDTH-1:0] r_a [NG];
   logic [WIDTH-1:0] r_b [NG];
   logic [WIDTH-1:0] r_s [NG];
   logic [NG-1:0]    r_c;
   logic [NG-1:0]    r_v;
   logic [WIDTH-1:0] w_ia [NG];
   logic [WIDTH-1:0] w_ib [NG];
   logic [WIDTH-1:0] w_is [NG];
   logic [NG-1:0]    w_ic;
   logic [NG-1:0]    w_iv;
   logic [5:0]       w_gr [NG];
   logic             w_adv;
   // Returns {carry into bit 3, group carry-out, 4 sum bits}.
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g = x & y;
      p = x ^ y;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[3], c[4], p ^ c[3:0]};
   endfunction
   assign w_adv     = ~r_v[NG-1] | out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_v[NG-1];
   assign s         = r_s[NG-1];
   assign cout      = r_c[NG-1];
   // Group 0 works straight off the conditioned operands so latency equals NG.
   always_comb begin
      w_ia[0] = a;
      w_ib[0] = sub ? ~b : b;
      w_ic[0] = sub | cin;
      w_is[0] = '0;
      w_iv[0] = in_valid;
      for (int k = 1; k < NG; k++) begin
         w_ia[k] = r_a[k-1];
         w_ib[k] = r_b[k-1];
         w_ic[k] = r_c[k-1];
         w_is[k] = r_s[k-1];
         w_iv[k] = r_v[k-1];
      end
      for (int k = 0; k < NG; k++) begin
         w_gr[k] = cla4(w_ia[k][4*k +: 4], w_ib[k][4*k +: 4], w_ic[k]);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= '0;
         r_c <= '0;
         for (int k = 0; k < NG; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
      end else if (w_adv) begin
         for (int k = 0; k < NG; k++) begin
            r_v[k] <= w_iv[k];
            r_c[k] <= w_gr[k][4];
            r_a[k] <= w_ia[k];
            r_b[k] <= w_ib[k];
            r_s[k] <= w_is[k] | (WIDTH'(w_gr[k][3:0]) << (4 * k));
         end
      end
   end
`ifdef CLA_OVF_EN
   logic r_ovf;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ovf <= 1'b0;
      else if (w_adv) r_ovf <= w_gr[NG-1][5] ^ w_gr[NG-1][4];
   end
   assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: scoreboard bench for cla_pipe_adder at WIDTH=16 (ovf checked when CLA_OVF_EN is defined).
module tb_cla_pipe_adder;
   localparam int W  = 16;
   localparam int NG = 4;
   logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
   logic in_ready, out_valid, cout;
   logic [W-1:0] a = '0, b = '0, s, s0;
`ifdef CLA_OVF_EN
   logic ovf;
`endif
   typedef struct {logic [W:0] r; logic o; logic lat; int acc;} exp_t;
   exp_t exp_q[$];
   exp_t pend;
   int checks = 0, errors = 0, cyc = 0, n_in = 0, n_out = 0;
   bit done = 0;
   always #5 clk = ~clk;
   cla_pipe_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .s(s), .cout(cout)
`ifdef CLA_OVF_EN
      , .ovf(ovf)
`endif
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask
   function automatic exp_t mk(input logic [W:0] r, input logic o, input logic lat);
      exp_t e;
      e.r = r; e.o = o; e.lat = lat; e.acc = 0;
      return e;
   endfunction
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic sb);
      exp_t e;
      logic [W-1:0] be;
      be = sb ? ~y : y;
      e.r = {1'b0, x} + {1'b0, be} + (W+1)'(sb | c);
      e.o = (x[W-1] == be[W-1]) && (e.r[W-1] != x[W-1]);
      e.lat = 0; e.acc = 0;
      return e;
   endfunction
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin : push
      exp_t e;
      if (rst_n && in_valid && in_ready) begin
         e = pend;
         e.acc = cyc;
         exp_q.push_back(e);
         n_in++;
      end
   end
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) chk("unexpected_out", {15'b0, cout, s}, 32'hDEAD);
         else begin
            e = exp_q.pop_front();
            chk("result", {15'b0, cout, s}, {15'b0, e.r});
            if (e.lat) chk("latency", cyc - e.acc, NG);
`ifdef CLA_OVF_EN
            chk("ovf", {31'b0, ovf}, {31'b0, e.o});
`endif
         end
      end
   end
   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts, input exp_t e);
      int n = 0;
      a = ta; b = tb; cin = tc; sub = ts; pend = e; in_valid = 1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 0;
   endtask
   task automatic issue_rand();
      logic [W-1:0] x, y;
      logic c, sb;
      x = W'($urandom); y = W'($urandom);
      c = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      issue(x, y, c, sb, model(x, y, c, sb));
   endtask
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   initial begin
      #12;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_s", {16'b0, s}, 0);
      chk("rst_cout", {31'b0, cout}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      @(posedge clk);
      #1 rst_n = 1;
      issue(16'h1234, 16'h1111, 0, 0, mk(17'h02345, 0, 1));
      issue(16'hFFFF, 16'h0001, 0, 0, mk(17'h10000, 0, 1));
      issue(16'h00FF, 16'h0000, 1, 0, mk(17'h00100, 0, 1));
      drain();
      issue(16'h0005, 16'h0007, 0, 1, mk(17'h0FFFE, 0, 0));
      issue(16'h8000, 16'h8000, 0, 1, mk(17'h10000, 0, 0));
      issue(16'h8000, 16'h0001, 0, 1, mk(17'h17FFF, 1, 0));
      issue(16'h0003, 16'h0001, 1, 1, mk(17'h10002, 0, 0));
      issue(16'h7FFF, 16'h0001, 0, 0, mk(17'h08000, 1, 0));
      issue(16'hFFFF, 16'hFFFF, 0, 0, mk(17'h1FFFE, 0, 0));
      drain();
      // Reset with two ops in flight; nothing they carried may ever emerge.
      @(posedge clk);
      #1 in_valid = 1; a = 16'h0001; b = 16'h0002; cin = 0; sub = 0; pend = model(a, b, cin, sub);
      @(posedge clk);
      #1 a = 16'h0003; pend = model(a, b, cin, sub);
      @(posedge clk);
      #1 a = 16'h0005; pend = model(a, b, cin, sub);
      #1 rst_n = 0; in_valid = 0;
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 0);
      chk("midrst_s", {16'b0, s}, 0);
      chk("midrst_cout", {31'b0, cout}, 0);
      chk("midrst_in_ready", {31'b0, in_ready}, 1);
      exp_q.delete();
      n_in = n_out;
      @(posedge clk);
      #1 rst_n = 1;
      repeat (8) @(negedge clk);
      chk("no_stale", {31'b0, out_valid}, 0);
      // Backpressure: the pipe fills, then must hold until released.
      out_ready = 0;
      fork
         for (int i = 0; i < 6; i++) issue_rand();
         begin
            int n = 0;
            while (!out_valid && n < 100) begin
               @(negedge clk);
               n++;
            end
            s0 = s;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("bp_in_ready", {31'b0, in_ready}, 0);
               chk("bp_out_valid", {31'b0, out_valid}, 1);
               chk("bp_s_stable", {16'b0, s}, {16'b0, s0});
            end
            @(posedge clk);
            #1 out_ready = 1;
         end
      join
      drain();
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               issue_rand();
               @(posedge clk);
               #1;
            end
            done = 1;
         end
         while (!done) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
         end
      join
      out_ready = 1;
      drain();
      chk("in_out_count", n_out, n_in);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined successor to the 4-bit carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into WIDTH/4 four-bit lookahead groups, one pipeline stage per group.
- Group carry-out is registered into the next stage, giving one result per cycle at high clock rate.
- Sits in the datapath between operand registers and downstream consumers; valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4 (elaboration error otherwise).
- NG, WIDTH/4 (derived localparam, not overridable), number of groups = pipeline depth.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  0 = A+B+cin; 1 = A−B (cin ignored)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry-out of MSB group; for subtract, 1 = no borrow
- ovf  output  1  signed overflow (only with CLA_OVF_EN)

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, s, cout, ovf, and internal carry/data registers clear to 0.
  - in_ready is combinational, so it reads 1 while in reset.
  - Any in-flight operations are discarded.
  - Deassertion is synchronised by the integrator; the block needs no extra cycle.
- Operand conditioning at acceptance:
  - b_eff = sub ? ~b : b.
  - c_in_eff = sub ? 1 : cin.
- Stage k (k = 0..NG−1):
  - Holds the unconsumed upper operand bits, the partial result bits [4k−1:0], the incoming group carry, and a valid bit.
  - Computes group k from per-bit generate g=a&b_eff and propagate p=a^b_eff.
  - Carries use full 4-bit lookahead, c[i+1] = g[i] | p[i]&c[i] expanded two-level; sum bit = p ^ c.
  - Registers sum bits [4k+3:4k] and the group carry-out into stage k+1.
- Last stage register drives s, cout, out_valid directly (registered outputs, no combinational path from a/b).
- Latency: exactly NG cycles from acceptance (in_valid & in_ready at edge) to out_valid, with no stall.
- Throughput: one operation per cycle.
- Handshake:
  - Global advance = ~out_valid | out_ready.
  - in_ready = advance.
  - All stages shift only when advance = 1.
  - Bubbles (in_valid=0 when advance) propagate as valid=0 slots.
  - When advance = 0, every stage and output holds; s/cout stable while out_valid & ~out_ready.
- Simultaneous out_ready and in_valid with a full pipe: the result is consumed and new operands accepted in the same edge; no loss or duplication.
- Wrap-around:
  - Arithmetic is modulo 2^WIDTH.
  - 0xFFFF+1 (WIDTH=16) gives s=0x0000, cout=1.
- Subtract:
  - A−B with A<B unsigned wraps (two's complement); cout=0 indicates borrow.
  - A==B gives s=0, cout=1.
- Degenerate WIDTH=4: single stage, latency 1, identical arithmetic to the 4-bit CLA.

Optional Feature:
- Macro CLA_OVF_EN.
- Defined:
  - Port ovf is present.
  - The final stage computes ovf = carry into MSB ^ carry out of MSB.
  - ovf is registered alongside s and held/reset identically.
- Undefined: the ovf port and its logic are absent; all other behaviour is unchanged.

Test Plan (WIDTH=16, NG=4):
1. Reset mid-stream: issue 3 back-to-back adds, assert rst_n=0 on cycle 2 → out_valid=0, s=0, cout=0 immediately (asynchronous); after release, no stale result ever appears.
2. Latency/throughput, out_ready=1:
   - Inputs: a=0x1234+b=0x1111 cin=0, then a=0xFFFF+b=0x0001 cin=0, then a=0x00FF+b=0x0000 cin=1.
   - Expected: s=0x2345/cout=0 exactly 4 cycles after the first accept, then s=0x0000/cout=1, then s=0x0100/cout=0 on consecutive cycles.
3. Subtract:
   - a=0x0005, b=0x0007, sub=1 → s=0xFFFE, cout=0.
   - a=0x8000, b=0x8000, sub=1 → s=0x0000, cout=1.
   - With CLA_OVF_EN: a=0x8000, b=0x0001, sub=1 → s=0x7FFF, ovf=1.
4. Backpressure:
   - Fill the pipe with 6 random ops, hold out_ready=0 for 5 cycles → in_ready=0 while out_valid=1; s stable.
   - Release → all 6 results emerge in order, matching the reference model (a±b mod 2^16).
5. Bubbles: alternate in_valid 1/0 with out_ready toggling randomly for 1000 ops → every result matches the model, count in equals count out, no duplicates.
6. Overflow (CLA_OVF_EN): 0x7FFF+0x0001 → s=0x8000, ovf=1, cout=0; 0xFFFF+0xFFFF → s=0xFFFE, ovf=0, cout=1.
